// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the data-memory controller: FSM states,
// word geometry and the reason codes behind a rejected request.
package mips_mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_t;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_CONFLICT = 2'd1;
    localparam logic [1:0] FAULT_MISALIGN = 2'd2;
    localparam logic [1:0] FAULT_RANGE    = 2'd3;

    // First matching reason wins; no request at all is never a fault.
    function automatic logic [1:0] fault_reason(
        input logic              rd,
        input logic              wr,
        input logic [WORD_W-1:0] addr,
        input int unsigned       depth
    );
        if (!(rd || wr))
            return FAULT_NONE;
        if (rd && wr)
            return FAULT_CONFLICT;
        if (addr[1:0] != 2'b00)
            return FAULT_MISALIGN;
        if (32'(addr[WORD_W-1:2]) >= depth)
            return FAULT_RANGE;
        return FAULT_NONE;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter for access wait states: loaded on accept, decremented while
// busy, flags the final wait cycle.
module mem_wait_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         last
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst)
            count_reg <= '0;
        else if (load)
            count_reg <= load_value;
        else if (dec && count_reg != '0)
            count_reg <= count_reg - W'(1);
    end

    assign count = count_reg;
    assign last  = (count_reg == W'(1));

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory controller: stalls the core for a fixed number of
// wait states per access and rejects malformed requests without side effects.
module data_mem_ctrl
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic              clk,
    input  logic              PCinit,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata,
    output logic              stall,
    output logic              done,
    output logic              err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LAT + 1);

    mem_state_t        state_reg, state_next;
    logic              op_write_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [WORD_W-1:0] wdata_reg;
    logic [WORD_W-1:0] rdata_reg;

    logic [1:0]        fault_code;
    logic              in_idle;
    logic              accept;
    logic              commit;
    logic [CNT_W-1:0]  cnt_value;
    logic              cnt_last;

    logic [WORD_W-1:0] mem [DEPTH];

    assign fault_code = fault_reason(MemRead, MemWrite, addr, DEPTH);
    assign in_idle    = (state_reg == ST_IDLE);
    assign accept     = in_idle && (MemRead || MemWrite) && (fault_code == FAULT_NONE);
    assign commit     = (state_reg == ST_BUSY) && cnt_last;

    mem_wait_counter #(
        .W (CNT_W)
    ) u_wait (
        .clk        (clk),
        .srst       (PCinit),
        .load       (accept),
        .load_value (CNT_W'(LAT)),
        .dec        (state_reg == ST_BUSY),
        .count      (cnt_value),
        .last       (cnt_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)   state_next = ST_BUSY;
            ST_BUSY: if (cnt_last) state_next = ST_DONE;
            // The request still visible here belongs to the finished access.
            ST_DONE:               state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (PCinit)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_write_reg <= MemWrite;
            idx_reg      <= addr[IDX_W+1:2];
            wdata_reg    <= wdata;
        end
    end

    // Reset on the commit edge drops the pending store.
    always_ff @(posedge clk) begin
        if (!PCinit && commit && op_write_reg)
            mem[idx_reg] <= wdata_reg;
    end

    always_ff @(posedge clk) begin
        if (PCinit)
            rdata_reg <= '0;
        else if (commit && !op_write_reg)
            rdata_reg <= mem[idx_reg];
    end

    assign rdata = rdata_reg;
    assign stall = accept || (state_reg == ST_BUSY);
    assign done  = (state_reg == ST_DONE);
    assign err   = in_idle && (fault_code != FAULT_NONE);

    logic unused_ok;
    assign unused_ok = ^cnt_value;

endmodule
